mem_req_unit: RTL and testbench

- MEM-stage data-memory request issuer: accepts load/store ops from EX, drives the SRAM-like data bus (req/addr_ok/data_ok), collects load data and hands a registered payload to WB.
- Produces the aligned write data and byte strobes for stores; WB performs load extraction and extension.
- Sits between the EX stage and the WB stage, on the data-side memory interface.

---
 rtl/mem_req_if.sv | 24 ++
 rtl/mem_req_unit.sv | 152 +++++++++++++++
 tb/tb_mem_req_unit.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_if.sv
// Data-side SRAM-like bus between the MEM-stage request issuer (master) and data memory (slave).
interface mem_req_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
             data_sram_wstrb, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/mem_req_unit.sv
// MEM-stage data-memory request issuer: EX payload in, SRAM-like bus request out, registered WB payload.
// Define MEM_ALE_EN to flag misaligned half/word accesses on out_ale instead of issuing them.
module mem_req_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_result,
   input  logic [31:0] PC,
   input  logic [7:0]  load_op,
   input  logic [2:0]  store_op,
   input  logic [31:0] store_data,
   input  logic        res_from_mem,
   input  logic        gr_we,
   input  logic [4:0]  dest,
   mem_req_if.master   dmem,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_PC,
   output logic [7:0]  out_load_op,
   output logic        out_res_from_mem,
   output logic        out_gr_we,
   output logic [4:0]  out_dest,
   output logic [31:0] out_rdata
`ifdef MEM_ALE_EN
   ,
   output logic        out_ale
`endif
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              state;
   logic                accept_c;
   logic                is_store_c;
   logic                mem_op_c;
   logic                issue_c;
   logic                wb_gr_we_c;
   logic [1:0]          size_c;
   logic [STRB_W-1:0]   wstrb_c;
   logic [DATA_W-1:0]   wdata_c;
`ifdef MEM_ALE_EN
   logic                ale_c;
`endif

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept_c = in_valid && in_ready;

   // Bus request attributes derived from the incoming EX payload.
   always_comb begin
      is_store_c = |store_op;
      mem_op_c   = res_from_mem | is_store_c;
      if (store_op[0] | load_op[0] | load_op[3])      size_c = 2'd0;
      else if (store_op[1] | load_op[1] | load_op[4]) size_c = 2'd1;
      else                                            size_c = 2'd2;
      wstrb_c = '0;
      wdata_c = store_data;
      if (store_op[0]) begin
         wstrb_c = STRB_W'(4'b0001 << alu_result[1:0]);
         wdata_c = {4{store_data[7:0]}};
      end else if (store_op[1]) begin
         wstrb_c = STRB_W'(4'b0011 << {alu_result[1], 1'b0});
         wdata_c = {2{store_data[15:0]}};
      end else if (store_op[2]) begin
         wstrb_c = '1;
      end
`ifdef MEM_ALE_EN
      ale_c = mem_op_c && (((size_c == 2'd1) && alu_result[0]) ||
                           ((size_c == 2'd2) && (alu_result[1:0] != 2'b00)));
      issue_c    = mem_op_c & ~ale_c;
      wb_gr_we_c = gr_we & ~ale_c;
`else
      issue_c    = mem_op_c;
      wb_gr_we_c = gr_we;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         dmem.data_sram_req   <= 1'b0;
         dmem.data_sram_wr    <= 1'b0;
         dmem.data_sram_size  <= 2'd0;
         dmem.data_sram_addr  <= '0;
         dmem.data_sram_wstrb <= '0;
         dmem.data_sram_wdata <= '0;
         out_valid            <= 1'b0;
         out_alu_result       <= '0;
         out_PC               <= '0;
         out_load_op          <= '0;
         out_res_from_mem     <= 1'b0;
         out_gr_we            <= 1'b0;
         out_dest             <= '0;
         out_rdata            <= '0;
`ifdef MEM_ALE_EN
         out_ale              <= 1'b0;
`endif
      end else if (accept_c) begin
         out_alu_result       <= alu_result;
         out_PC               <= PC;
         out_load_op          <= load_op;
         out_res_from_mem     <= res_from_mem;
         out_gr_we            <= wb_gr_we_c;
         out_dest             <= dest;
         out_rdata            <= '0;
`ifdef MEM_ALE_EN
         out_ale              <= ale_c;
`endif
         dmem.data_sram_addr  <= ADDR_W'(alu_result);
         dmem.data_sram_wr    <= is_store_c;
         dmem.data_sram_size  <= size_c;
         dmem.data_sram_wstrb <= wstrb_c;
         dmem.data_sram_wdata <= wdata_c;
         if (issue_c) begin
            state              <= REQ;
            dmem.data_sram_req <= 1'b1;
            out_valid          <= 1'b0;
         end else begin
            state              <= DONE;
            out_valid          <= 1'b1;
         end
      end else begin
         // Handshakes arriving in a state that does not expect them are ignored.
         case (state)
            REQ: begin
               if (dmem.data_sram_addr_ok) begin
                  dmem.data_sram_req <= 1'b0;
                  state              <= WAIT;
               end
            end
            WAIT: begin
               if (dmem.data_sram_data_ok) begin
                  if (out_res_from_mem) out_rdata <= dmem.data_sram_rdata;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_req_unit.sv
// Bench for mem_req_unit: directed scenarios plus random traffic, checked by a queue-based scoreboard.
// Build with +define+MEM_ALE_EN to exercise the misaligned-access flag.
module tb_mem_req_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] alu_result, PC, store_data;
   logic [7:0]  load_op;
   logic [2:0]  store_op;
   logic        res_from_mem, gr_we;
   logic [4:0]  dest;
   logic        out_valid, out_ready;
   logic [31:0] out_alu_result, out_PC, out_rdata;
   logic [7:0]  out_load_op;
   logic        out_res_from_mem, out_gr_we;
   logic [4:0]  out_dest;
`ifdef MEM_ALE_EN
   logic        out_ale;
`endif

   mem_req_if bus();

   mem_req_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .PC(PC), .load_op(load_op), .store_op(store_op),
      .store_data(store_data), .res_from_mem(res_from_mem), .gr_we(gr_we), .dest(dest),
      .dmem(bus), .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_result(out_alu_result), .out_PC(out_PC), .out_load_op(out_load_op),
      .out_res_from_mem(out_res_from_mem), .out_gr_we(out_gr_we), .out_dest(out_dest),
      .out_rdata(out_rdata)
`ifdef MEM_ALE_EN
      , .out_ale(out_ale)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu, pc;
      logic [7:0]  lop;
      logic        rfm, gwe, ale, mem;
      logic [4:0]  dst;
   } wb_t;
   typedef struct {
      logic [31:0] addr, wdata;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
   } bus_t;

   wb_t         wb_q[$];
   bus_t        bus_q[$];
   logic [31:0] rd_q[$];
   int          errors = 0, checks = 0, wb_count = 0;
   logic        outstanding = 1'b0;
   logic [7:0]  load_sel [5] = '{8'h01, 8'h08, 8'h02, 8'h10, 8'h04};
   logic [2:0]  store_sel [3] = '{3'b001, 3'b010, 3'b100};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: access width in bytes, lane placement and replication from the access rules.
   task automatic predict();
      wb_t         w;
      bus_t        b;
      int unsigned nbytes, base;
      logic        is_store, is_mem, ale;
      is_store = (store_op != 3'b000);
      is_mem   = res_from_mem || is_store;
      if (store_op[0] || load_op[0] || load_op[3])      nbytes = 1;
      else if (store_op[1] || load_op[1] || load_op[4]) nbytes = 2;
      else                                              nbytes = 4;
      ale = 1'b0;
`ifdef MEM_ALE_EN
      ale = is_mem && ((alu_result % nbytes) != 0);
`endif
      base    = ((alu_result % 4) / nbytes) * nbytes;
      b.addr  = alu_result;
      b.wr    = is_store;
      b.size  = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
      b.wstrb = 4'b0000;
      b.wdata = 32'h0;
      for (int lane = 0; lane < 4; lane++) begin
         b.wdata[lane*8 +: 8] = store_data[(lane % int'(nbytes))*8 +: 8];
         if (is_store && lane >= int'(base) && lane < int'(base + nbytes)) b.wstrb[lane] = 1'b1;
      end
      w.alu = alu_result; w.pc = PC; w.lop = load_op; w.rfm = res_from_mem;
      w.gwe = gr_we && !ale; w.dst = dest; w.ale = ale; w.mem = is_mem;
      wb_q.push_back(w);
      if (is_mem && !ale) bus_q.push_back(b);
   endtask

   // Monitor: every handshake is evaluated mid-cycle, where it is certain to commit at the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            wb_q.delete(); bus_q.delete(); rd_q.delete();
            outstanding = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               check("wb_pending", 32'(wb_q.size() != 0), 32'd1);
               if (wb_q.size() != 0) begin
                  wb_t         w;
                  logic [31:0] r;
                  w = wb_q.pop_front();
                  r = 32'h0;
                  wb_count++;
                  if (w.mem && !w.ale) begin
                     check("rdata_pending", 32'(rd_q.size() != 0), 32'd1);
                     if (rd_q.size() != 0) r = rd_q.pop_front();
                     if (!w.rfm) r = 32'h0;
                  end
                  check("wb_alu", out_alu_result, w.alu);
                  check("wb_pc", out_PC, w.pc);
                  check("wb_load_op", 32'(out_load_op), 32'(w.lop));
                  check("wb_rfm", 32'(out_res_from_mem), 32'(w.rfm));
                  check("wb_gr_we", 32'(out_gr_we), 32'(w.gwe));
                  check("wb_dest", 32'(out_dest), 32'(w.dst));
                  check("wb_rdata", out_rdata, r);
`ifdef MEM_ALE_EN
                  check("wb_ale", 32'(out_ale), 32'(w.ale));
`endif
               end
            end
            if (outstanding && bus.data_sram_data_ok) begin
               rd_q.push_back(bus.data_sram_rdata);
               outstanding = 1'b0;
            end
            if (bus.data_sram_req && bus.data_sram_addr_ok) begin
               check("bus_pending", 32'(bus_q.size() != 0), 32'd1);
               if (bus_q.size() != 0) begin
                  bus_t b;
                  b = bus_q.pop_front();
                  check("bus_addr", bus.data_sram_addr, b.addr);
                  check("bus_wr", 32'(bus.data_sram_wr), 32'(b.wr));
                  check("bus_size", 32'(bus.data_sram_size), 32'(b.size));
                  check("bus_wstrb", 32'(bus.data_sram_wstrb), 32'(b.wstrb));
                  if (b.wr) check("bus_wdata", bus.data_sram_wdata, b.wdata);
               end
               outstanding = 1'b1;
            end
            if (in_valid && in_ready) predict();
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] a, input logic [7:0] lop, input logic [2:0] sop,
                         input logic rfm, input logic [31:0] sd);
      alu_result = a; load_op = lop; store_op = sop; res_from_mem = rfm; store_data = sd;
      gr_we = (sop == 3'b000); dest = 5'($urandom); PC = $urandom;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      set_op(32'h0, 8'h0, 3'b000, 1'b0, 32'h0);
      bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'h0;
      repeat (3) cyc();
      @(negedge clk);
      check("rst_req", 32'(bus.data_sram_req), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_alu", out_alu_result, 32'h0);
      check("rst_out_rdata", out_rdata, 32'h0);
      cyc();
      rst = 1'b0;

      // Non-memory op completes the cycle after acceptance with no bus request.
      out_ready = 1'b1;
      set_op(32'h1234, 8'h0, 3'b000, 1'b0, 32'h0); in_valid = 1'b1;
      @(negedge clk); check("nm_in_ready", 32'(in_ready), 32'd1); cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("nm_out_valid", 32'(out_valid), 32'd1);
      check("nm_out_alu", out_alu_result, 32'h1234);
      check("nm_no_req", 32'(bus.data_sram_req), 32'd0);
      cyc();
      @(negedge clk); check("nm_idle", 32'(out_valid), 32'd0); cyc();

      // SB to the top byte lane, request held until addr_ok.
      set_op(32'h1003, 8'h0, 3'b001, 1'b0, 32'hAABBCCDD); in_valid = 1'b1;
      @(negedge clk); cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("sb_req", 32'(bus.data_sram_req), 32'd1);
      check("sb_wr", 32'(bus.data_sram_wr), 32'd1);
      check("sb_size", 32'(bus.data_sram_size), 32'd0);
      check("sb_wstrb", 32'(bus.data_sram_wstrb), 32'h8);
      check("sb_wdata", bus.data_sram_wdata, 32'hDDDDDDDD);
      cyc();
      @(negedge clk); check("sb_req_hold", 32'(bus.data_sram_req), 32'd1); cyc();
      bus.data_sram_addr_ok = 1'b1;
      @(negedge clk); check("sb_req_hold2", 32'(bus.data_sram_req), 32'd1); cyc();
      bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h13572468;
      @(negedge clk);
      check("sb_req_drop", 32'(bus.data_sram_req), 32'd0);
      check("sb_wait_valid", 32'(out_valid), 32'd0);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk); check("sb_done_valid", 32'(out_valid), 32'd1); cyc();

      // LW with immediate addr_ok and data two cycles later, then WB back-pressure.
      set_op(32'h2000, 8'h04, 3'b000, 1'b1, 32'h0); gr_we = 1'b1; in_valid = 1'b1;
      @(negedge clk); cyc();
      in_valid = 1'b0; bus.data_sram_addr_ok = 1'b1;
      @(negedge clk);
      check("lw_req", 32'(bus.data_sram_req), 32'd1);
      check("lw_wstrb", 32'(bus.data_sram_wstrb), 32'h0);
      check("lw_size", 32'(bus.data_sram_size), 32'd2);
      check("lw_wr", 32'(bus.data_sram_wr), 32'd0);
      cyc();
      bus.data_sram_addr_ok = 1'b0;
      @(negedge clk); check("lw_req_drop", 32'(bus.data_sram_req), 32'd0); cyc();
      bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hCAFEF00D; out_ready = 1'b0;
      @(negedge clk); check("lw_wait_valid", 32'(out_valid), 32'd0); cyc();
      bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_rdata", out_rdata, 32'hCAFEF00D);
         check("bp_load_op", 32'(out_load_op), 32'h04);
         cyc();
      end
      out_ready = 1'b1;
      set_op(32'h55, 8'h0, 3'b000, 1'b0, 32'h0); in_valid = 1'b1;
      @(negedge clk); check("b2b_in_ready", 32'(in_ready), 32'd1); cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_out_alu", out_alu_result, 32'h55);
      cyc();

      // Reset while waiting for data; the late data_ok must be dropped.
      set_op(32'h40, 8'h04, 3'b000, 1'b1, 32'h0); in_valid = 1'b1; bus.data_sram_addr_ok = 1'b1;
      @(negedge clk); cyc();
      in_valid = 1'b0;
      @(negedge clk); check("rw_req", 32'(bus.data_sram_req), 32'd1); cyc();
      bus.data_sram_addr_ok = 1'b0; rst = 1'b1;
      @(negedge clk); cyc();
      rst = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rw_req_low", 32'(bus.data_sram_req), 32'd0);
      check("rw_out_valid", 32'(out_valid), 32'd0);
      check("rw_in_ready", 32'(in_ready), 32'd1);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk); check("rw_ignored", 32'(out_valid), 32'd0); cyc();

`ifdef MEM_ALE_EN
      // Misaligned SW is flagged and completes without touching the bus.
      set_op(32'h3002, 8'h0, 3'b100, 1'b0, 32'h12345678); gr_we = 1'b1; in_valid = 1'b1;
      @(negedge clk); cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("ale_no_req", 32'(bus.data_sram_req), 32'd0);
      check("ale_flag", 32'(out_ale), 32'd1);
      check("ale_gr_we", 32'(out_gr_we), 32'd0);
      check("ale_out_valid", 32'(out_valid), 32'd1);
      cyc();
`else
      // Misaligned SH is issued as-is with its computed strobes.
      set_op(32'h3003, 8'h0, 3'b010, 1'b0, 32'h0000BEEF); in_valid = 1'b1;
      @(negedge clk); cyc();
      in_valid = 1'b0; bus.data_sram_addr_ok = 1'b1;
      @(negedge clk);
      check("mis_req", 32'(bus.data_sram_req), 32'd1);
      check("mis_wstrb", 32'(bus.data_sram_wstrb), 32'hC);
      check("mis_wdata", bus.data_sram_wdata, 32'hBEEFBEEF);
      cyc();
      bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b1;
      @(negedge clk); cyc();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk); check("mis_out_valid", 32'(out_valid), 32'd1); cyc();
`endif

      // Random traffic against the scoreboard.
      for (int i = 0; i < 4000; i++) begin
         int unsigned kind;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         a    = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         if (kind == 0)      set_op(a, 8'h0, 3'b000, 1'b0, $urandom);
         else if (kind == 1) set_op(a, load_sel[$urandom_range(0, 4)] | (8'($urandom) & 8'hE0),
                                    3'b000, 1'b1, $urandom);
         else                set_op(a, 8'h0, store_sel[$urandom_range(0, 2)], 1'b0, $urandom);
         if (kind == 1) gr_we = 1'b1;
         in_valid              = ($urandom_range(0, 9) < 6);
         out_ready             = ($urandom_range(0, 3) != 0);
         bus.data_sram_addr_ok = ($urandom_range(0, 2) == 0);
         bus.data_sram_data_ok = ($urandom_range(0, 2) == 0);
         bus.data_sram_rdata   = $urandom;
         rst                   = ($urandom_range(0, 499) == 0);
         cyc();
      end

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      bus.data_sram_addr_ok = 1'b1; bus.data_sram_data_ok = 1'b1;
      repeat (10) cyc();
      @(negedge clk);
      check("drain_wb", 32'(wb_q.size()), 32'd0);
      check("drain_bus", 32'(bus_q.size()), 32'd0);
      check("progress", 32'(wb_count >= 100), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
